// File: rtl/dds_sweep_ctrl_pkg.sv
// Shared types and constants for the DDS sweep frame sequencer.
// Tuning words follow ftw = f * 2^32 / fs, with fs = 500 MHz.
package dds_ctrl_pkg;

  localparam logic [31:0] DEF_FTW_I = 32'd4294967;   // 500 kHz
  localparam logic [31:0] DEF_FTW_Q = 32'd12884902;  // 1.5 MHz

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FLUSH,
    ST_RUN,
    ST_STEP
  } state_e;

  // A zero frame count still produces one frame.
  function automatic logic [15:0] nframes_eff(input logic [15:0] n);
    return (n == 16'd0) ? 16'd1 : n;
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Host/generator-side signal bundle of the DDS sweep frame sequencer.
interface dds_sweep_ctrl_if #(
  parameter int CW = 32
) ();
  logic          start;
  logic          abort;
  logic [CW-1:0] cfg_ftw_i;
  logic [CW-1:0] cfg_ftw_q;
  logic [CW-1:0] cfg_step;
  logic [15:0]   cfg_nframes;
  logic          fft_ready;
  logic [CW-1:0] ftw_i;
  logic [CW-1:0] ftw_q;
  logic          acc_clr;
  logic          s_valid;
  logic          s_last;
  logic          busy;
  logic          done;
  logic          overrun;

  modport master (
    output start, abort, cfg_ftw_i, cfg_ftw_q, cfg_step, cfg_nframes, fft_ready,
    input  ftw_i, ftw_q, acc_clr, s_valid, s_last, busy, done, overrun
  );

  modport slave (
    input  start, abort, cfg_ftw_i, cfg_ftw_q, cfg_step, cfg_nframes, fft_ready,
    output ftw_i, ftw_q, acc_clr, s_valid, s_last, busy, done, overrun
  );
endinterface

// File: rtl/dds_sweep_ctrl_timer.sv
// Loadable down-counter timing both the generator flush and the frame length.
module dds_frame_timer #(
  parameter int TW = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [TW-1:0] load_val_i,
  input  logic          en_i,
  output logic          tc_o
);
  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/dds_sweep_ctrl.sv
// Frame sequencer: programs the two-tone DDS, clears its accumulators and
// gates its sample stream into FFT frames while stepping the tuning words.
module dds_sweep_ctrl
  import dds_ctrl_pkg::*;
#(
  parameter int            CW        = 32,
  parameter int            FRAME_LEN = 1024,
  parameter int            GEN_LAT   = 2,
  parameter logic [CW-1:0] FTW_I_DEF = DEF_FTW_I,
  parameter logic [CW-1:0] FTW_Q_DEF = DEF_FTW_Q
) (
  input  logic              sclk,
  input  logic              rst,
  dds_sweep_ctrl_if.slave   bus
);
  localparam int            TW       = $clog2(FRAME_LEN + GEN_LAT + 1);
  localparam logic [TW-1:0] RUN_LOAD = TW'(FRAME_LEN - 1);
  localparam logic [TW-1:0] LAT_LOAD = TW'(GEN_LAT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wi_q, wq_q, step_q;
  logic [CW-1:0] wi_d, wq_d;
  logic [CW-1:0] ftw_i_q, ftw_q_q;
  logic [15:0]   nf_q, cnt_q;
  logic          acc_clr_q, s_valid_q, s_last_q, busy_q, done_q, overrun_q;

  logic          accept, arm_go, last_frame;
  logic          tmr_load, tmr_en, tmr_tc;
  logic [TW-1:0] tmr_val;

  dds_frame_timer #(.TW(TW)) u_timer (
    .clk        (sclk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    accept     = (state_q == ST_IDLE) && bus.start && !bus.abort;
    arm_go     = (state_q == ST_ARM) && bus.fft_ready && !bus.abort;
    last_frame = ((cnt_q + 16'd1) == nframes_eff(nf_q));
    wi_d       = wi_q + step_q;
    wq_d       = wq_q + step_q;
  end

  always_comb begin
    state_d  = state_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (bus.fft_ready) begin
          state_d  = ST_FLUSH;
          tmr_load = 1'b1;
          tmr_val  = LAT_LOAD;
        end
      end
      ST_FLUSH: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          state_d  = ST_RUN;
          tmr_load = 1'b1;
          tmr_val  = RUN_LOAD;
        end
      end
      ST_RUN: begin
        tmr_en = 1'b1;
        if (tmr_tc) state_d = ST_STEP;
      end
      ST_STEP: begin
        state_d = last_frame ? ST_IDLE : ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort overrides every transition, including a coincident start.
    if (bus.abort) state_d = ST_IDLE;
  end

  // Outputs are registered from the current state, so the sample stream
  // lags the RUN state by one cycle and lines up with generator latency.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wi_q      <= FTW_I_DEF;
      wq_q      <= FTW_Q_DEF;
      step_q    <= '0;
      nf_q      <= '0;
      cnt_q     <= '0;
      ftw_i_q   <= FTW_I_DEF;
      ftw_q_q   <= FTW_Q_DEF;
      acc_clr_q <= 1'b0;
      s_valid_q <= 1'b0;
      s_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != ST_IDLE);
      acc_clr_q <= arm_go;
      s_valid_q <= (state_q == ST_RUN) && !bus.abort;
      s_last_q  <= (state_q == ST_RUN) && tmr_tc && !bus.abort;
      done_q    <= (state_q == ST_STEP) && last_frame && !bus.abort;
      if (arm_go) begin
        ftw_i_q <= wi_q;
        ftw_q_q <= wq_q;
      end
      if (accept) begin
        wi_q      <= bus.cfg_ftw_i;
        wq_q      <= bus.cfg_ftw_q;
        step_q    <= bus.cfg_step;
        nf_q      <= bus.cfg_nframes;
        cnt_q     <= '0;
        overrun_q <= 1'b0;
      end else begin
        if ((state_q == ST_RUN) && !bus.fft_ready) overrun_q <= 1'b1;
        if ((state_q == ST_STEP) && !bus.abort) begin
          cnt_q <= cnt_q + 16'd1;
          if (!last_frame) begin
            wi_q <= wi_d;
            wq_q <= wq_d;
          end
        end
      end
    end
  end

  assign bus.ftw_i   = ftw_i_q;
  assign bus.ftw_q   = ftw_q_q;
  assign bus.acc_clr = acc_clr_q;
  assign bus.s_valid = s_valid_q;
  assign bus.s_last  = s_last_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl with a 16-sample frame and 2-cycle generator latency.
module tb_dds_sweep_ctrl;
  localparam int FL = 16;
  localparam int GL = 2;

  typedef struct packed {
    logic [31:0] fi;
    logic [31:0] fq;
    logic        last;
  } exp_t;

  logic sclk = 1'b0;
  logic rst  = 1'b0;
  int   cyc  = 0;

  dds_sweep_ctrl_if #(.CW(32)) dif ();

  dds_sweep_ctrl #(.CW(32), .FRAME_LEN(FL), .GEN_LAT(GL)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (dif)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt, acc_cnt, vld_cnt;
  int   first_acc, first_vld, last_cyc, done_cyc;
  int   zero_run   = 0;
  bit   prev_vld   = 1'b0;
  bit   seen_frame = 1'b0;
  int   t0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    done_cnt   = 0;
    acc_cnt    = 0;
    vld_cnt    = 0;
    first_acc  = -1;
    first_vld  = -1;
    last_cyc   = -1;
    done_cyc   = -1;
    seen_frame = 1'b0;
  endtask

  // Monitor: pops one expected sample per valid cycle.
  always @(negedge sclk) begin
    exp_t e;
    if (dif.acc_clr) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (dif.done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = cyc;
      chk("busy_at_done", dif.busy, 0);
    end
    if (dif.s_valid) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc;
      if (!prev_vld && seen_frame) chk("gap", zero_run, GL + 2);
      zero_run = 0;
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("ftw_i", dif.ftw_i, e.fi);
        chk("ftw_q", dif.ftw_q, e.fq);
        chk("s_last", dif.s_last, e.last);
      end
      if (dif.s_last) begin
        seen_frame = 1'b1;
        if (last_cyc < 0) last_cyc = cyc;
      end
    end else begin
      zero_run++;
    end
    prev_vld = dif.s_valid;
  end

  task automatic start_sweep(input logic [31:0] fi, input logic [31:0] fq,
                             input logic [31:0] step, input logic [15:0] n);
    int nf;
    logic [31:0] wi, wq;
    nf = (n == 0) ? 1 : int'(n);
    wi = fi;
    wq = fq;
    for (int f = 0; f < nf; f++) begin
      for (int s = 0; s < FL; s++) sb.push_back('{fi: wi, fq: wq, last: (s == FL - 1)});
      wi = wi + step;
      wq = wq + step;
    end
    clear_stats();
    @(posedge sclk);
    #1;
    dif.cfg_ftw_i   = fi;
    dif.cfg_ftw_q   = fq;
    dif.cfg_step    = step;
    dif.cfg_nframes = n;
    dif.start       = 1'b1;
    t0 = cyc;
    @(posedge sclk);
    #1;
    dif.start = 1'b0;
    chk("busy_t1", dif.busy, 1);
    chk("overrun_clr", dif.overrun, 0);
  endtask

  task automatic wait_done(input int budget);
    int i = 0;
    while (done_cnt == 0 && i < budget) begin
      @(negedge sclk);
      #1;
      i++;
    end
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    repeat (4) @(negedge sclk);
    #1;
  endtask

  task automatic wait_vld(input int n, input int budget);
    int i = 0;
    while (vld_cnt < n && i < budget) begin
      @(negedge sclk);
      #1;
      i++;
    end
    if (vld_cnt < n) chk("vld_timeout", vld_cnt, n);
  endtask

  task automatic sweep_end(input int nf);
    chk("done_cnt", done_cnt, 1);
    chk("acc_cnt", acc_cnt, nf);
    chk("vld_cnt", vld_cnt, nf * FL);
    chk("sb_left", sb.size(), 0);
    chk("busy_idle", dif.busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ftw_i"}, dif.ftw_i, 32'd4294967);
    chk({tag, "_ftw_q"}, dif.ftw_q, 32'd12884902);
    chk({tag, "_acc_clr"}, dif.acc_clr, 0);
    chk({tag, "_s_valid"}, dif.s_valid, 0);
    chk({tag, "_s_last"}, dif.s_last, 0);
    chk({tag, "_busy"}, dif.busy, 0);
    chk({tag, "_done"}, dif.done, 0);
    chk({tag, "_overrun"}, dif.overrun, 0);
  endtask

  initial begin
    dif.start       = 1'b0;
    dif.abort       = 1'b0;
    dif.cfg_ftw_i   = '0;
    dif.cfg_ftw_q   = '0;
    dif.cfg_step    = '0;
    dif.cfg_nframes = '0;
    dif.fft_ready   = 1'b1;
    clear_stats();
    #2 rst = 1'b1;
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    check_reset_vals("rst");
    rst = 1'b0;

    // Single frame with latency checks
    start_sweep(32'h0123_4567, 32'h00AB_CDEF, 32'd0, 16'd1);
    wait_done(200);
    sweep_end(1);
    chk("t_acc_clr", first_acc - t0, 2);
    chk("t_first_vld", first_vld - t0, 3 + GL);
    chk("t_last", last_cyc - t0, 2 + GL + FL);
    chk("t_done", done_cyc - t0, 3 + GL + FL);

    // Three-frame sweep
    start_sweep(32'd4294967, 32'd12884902, 32'd1000, 16'd3);
    wait_done(400);
    sweep_end(3);

    // Q word wraps through zero
    start_sweep(32'd100, 32'hFFFF_FC18, 32'd1000, 16'd2);
    wait_done(300);
    sweep_end(2);

    // FFT not ready at start, then drops mid-frame
    dif.fft_ready = 1'b0;
    start_sweep(32'h0000_1000, 32'h0000_2000, 32'd7, 16'd1);
    repeat (10) @(negedge sclk);
    #1;
    chk("hold_acc_clr", acc_cnt, 0);
    chk("hold_vld", vld_cnt, 0);
    chk("hold_busy", dif.busy, 1);
    dif.fft_ready = 1'b1;
    wait_vld(3, 100);
    dif.fft_ready = 1'b0;
    repeat (2) @(negedge sclk);
    #1;
    dif.fft_ready = 1'b1;
    wait_done(200);
    sweep_end(1);
    chk("overrun_sticky", dif.overrun, 1);

    // Abort on fifth sample; start while busy is ignored
    start_sweep(32'h1111_1111, 32'h2222_2222, 32'd5, 16'd2);
    @(posedge sclk);
    #1;
    dif.cfg_ftw_i = 32'hDEAD_BEEF;
    dif.cfg_ftw_q = 32'hCAFE_F00D;
    dif.start     = 1'b1;
    @(posedge sclk);
    #1;
    dif.start = 1'b0;
    wait_vld(5, 100);
    dif.abort = 1'b1;
    @(posedge sclk);
    #1;
    dif.abort = 1'b0;
    @(negedge sclk);
    chk("abort_vld", dif.s_valid, 0);
    chk("abort_busy", dif.busy, 0);
    repeat (40) @(negedge sclk);
    #1;
    chk("abort_done", done_cnt, 0);
    chk("abort_vld_cnt", vld_cnt, 5);
    chk("abort_acc", acc_cnt, 1);
    chk("abort_ftw_hold", dif.ftw_i, 32'h1111_1111);
    chk("abort_sb_left", sb.size(), 2 * FL - 5);
    sb.delete();

    // Start and abort together in IDLE
    @(posedge sclk);
    #1;
    dif.start = 1'b1;
    dif.abort = 1'b1;
    @(posedge sclk);
    #1;
    dif.start = 1'b0;
    dif.abort = 1'b0;
    chk("start_abort_busy", dif.busy, 0);

    // Zero frame count behaves as one
    start_sweep(32'h0BAD_0001, 32'h0BAD_0002, 32'd99, 16'd0);
    wait_done(200);
    sweep_end(1);

    // Asynchronous reset in the middle of a frame with overrun pending
    start_sweep(32'h5555_0000, 32'h6666_0000, 32'd1, 16'd2);
    wait_vld(2, 100);
    dif.fft_ready = 1'b0;
    repeat (2) @(negedge sclk);
    #1;
    chk("pre_rst_overrun", dif.overrun, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("async_rst");
    sb.delete();
    @(negedge sclk);
    rst = 1'b0;
    dif.fft_ready = 1'b1;
    repeat (3) @(negedge sclk);
    chk("post_rst_busy", dif.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1);
  end
endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frame sequencer for the two-tone DDS test generator feeding the FFT core. It issues the I/Q frequency tuning words and phase-accumulator clear, then gates the generator's sample stream into FFT frames of exactly FRAME_LEN samples with valid/last. Between frames it steps both tuning words, which produces a multi-frame frequency sweep. It sits between the register/host side and the tone generator → FFT input path.

## Interface
- CW, 32, phase accumulator / tuning word width
- FRAME_LEN, 1024, samples per FFT frame (power of 2, ≥4)
- GEN_LAT, 2, cycles from accumulator clear to first valid sample at generator output (accumulator register + ROM register)
- FTW_I_DEF, 32'd4294967, reset tuning word I (500 kHz)
- FTW_Q_DEF, 32'd12884902, reset tuning word Q (1.5 MHz)

- sclk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a sweep when idle
- abort  in  1  one-cycle pulse; terminates any activity
- cfg_ftw_i  in  CW  start tuning word I, sampled on accepted start
- cfg_ftw_q  in  CW  start tuning word Q, sampled on accepted start
- cfg_step  in  CW  per-frame increment added to both words
- cfg_nframes  in  16  frames per sweep; 0 treated as 1
- fft_ready  in  1  FFT able to accept a new frame
- ftw_i  out  CW  tuning word to generator I accumulator
- ftw_q  out  CW  tuning word to generator Q accumulator
- acc_clr  out  1  synchronous clear to both generator accumulators
- s_valid  out  1  current generator sample belongs to the frame
- s_last  out  1  final sample of frame
- busy  out  1  not IDLE
- done  out  1  one-cycle pulse after the final frame
- overrun  out  1  sticky; fft_ready dropped during RUN

## Operation
- States: IDLE, ARM, FLUSH, RUN, STEP.
- IDLE: start latches cfg_* into working registers → ARM. Start is ignored outside IDLE.
- ARM: waits for fft_ready=1. On the cycle fft_ready is seen, acc_clr=1 and ftw_i/ftw_q take the working words → FLUSH.
- FLUSH: counts GEN_LAT cycles, then → RUN.
- RUN: s_valid=1 for exactly FRAME_LEN consecutive cycles. s_last=1 on the FRAME_LEN-th cycle. The stream cannot stall. If fft_ready=0 in any RUN cycle, overrun is set and the frame still completes.
- STEP: one cycle. The frame counter increments.
  - If count == max(cfg_nframes,1): pulse done → IDLE.
  - Otherwise: working words += cfg_step, modulo 2^CW with silent wrap → ARM.
- abort in any state: next state IDLE, s_valid/s_last/acc_clr deassert from the next cycle, done is not pulsed, ftw outputs hold their last value.
- start and abort in the same IDLE cycle: abort wins and the block stays IDLE.
- overrun is cleared only by rst or an accepted start.

## Timing
- Reset values: ftw_i=FTW_I_DEF, ftw_q=FTW_Q_DEF, acc_clr=0, s_valid=0, s_last=0, busy=0, done=0, overrun=0, state IDLE, counters 0.
- All outputs are registered.
- start at cycle t with fft_ready=1 gives:
  - busy=1 at t+1
  - acc_clr=1 at t+2
  - first s_valid at t+3+GEN_LAT
  - s_last at t+2+GEN_LAT+FRAME_LEN
- Gap between frames with fft_ready held high: STEP + ARM + FLUSH = 2+GEN_LAT cycles of s_valid=0.
- done is asserted one cycle after the last STEP cycle. busy falls in the same cycle.
- rst asserted mid-frame: outputs return to reset values asynchronously.

## Structure
- Shared package dds_ctrl_pkg holds:
  - state enum
  - FTW_I_DEF/FTW_Q_DEF constants
  - conversion note ftw = f·2^32/fs, with fs = 500 MHz
- One natural sub-module, dds_frame_timer: a loadable down-counter shared by FLUSH (GEN_LAT) and RUN (FRAME_LEN), with a terminal-count output.
- The FSM, word adders and frame counter stay in the top.

## Test plan
- FRAME_LEN=16, GEN_LAT=2, cfg_nframes=1, fft_ready=1, start → exactly 16 s_valid cycles, s_last on the 16th, done once, ftw_i=cfg_ftw_i.
- cfg_nframes=3, cfg_step=1000, cfg_ftw_i=4294967 → ftw_i is 4294967, 4295967, 4296967 per frame. Inter-frame gap is 4 cycles. acc_clr pulses 3 times.
- cfg_ftw_q=32'hFFFFFC18, cfg_step=1000, 2 frames → second frame ftw_q=0 (wrap), no error.
- fft_ready low for 10 cycles after start → no acc_clr or s_valid until fft_ready rises. Drop fft_ready mid-RUN → frame completes and overrun=1 until the next start.
- abort on the 5th RUN cycle → s_valid=0 the next cycle, busy=0, no done. A start issued while busy is ignored.
- cfg_nframes=0 → behaves as 1 frame. rst asserted mid-RUN → all outputs at reset values immediately.
